// File: rtl/axis_wr_burst_pkg.sv
// Shared types and constants for the AXI-Stream to AXI4 write burst packer.
// Constants below describe the default 256-bit data path.
package axis_wr_burst_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 256;
  localparam int unsigned BYTES    = DEF_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);
  localparam int unsigned BEATS_4K = 4096 / BYTES;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    AW,
    W,
    DRAIN
  } wr_state_t;

endpackage

// File: rtl/wr_beat_fifo.sv
// Beat buffer between the stream and the AXI W channel.
// First-word fall-through head, registered occupancy count.
module wr_beat_fifo
  import axis_wr_burst_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array: written on accepted push only, never reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers and occupancy; reset empties the buffer.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axis_to_axi4_wr_burst.sv
// Packs one AXI-Stream frame into INCR AXI4 write bursts at consecutive
// addresses, never crossing a 4KB page, and reports frame done/error.
module axis_to_axi4_wr_burst
  import axis_wr_burst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST       = 64,
  parameter int unsigned FIFO_DEPTH      = 128,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(NBYTES);
  localparam int unsigned B4K    = 4096 / NBYTES;
  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW     = $clog2(MAX_OUTSTANDING + 1);

  wr_state_t             state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic                  awvalid_q;
  logic [8:0]            beat_cnt_q;
  logic [OW-1:0]         out_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  last_seen_q;

  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] head;
  logic [8:0]            len_d;
  logic                  issue_d;
  logic                  aw_hs;
  logic                  b_hs;
  logic [8:0]            burst_beats;
  logic [ADDR_WIDTH-1:0] addr_step;

  assign s_tready = busy_q && !full && !last_seen_q;
  assign push     = s_tvalid && s_tready;
  assign wvalid   = (state_q == W) && !empty;
  assign pop      = wvalid && wready;
  assign wlast    = (state_q == W) && (beat_cnt_q == 9'd1);
  assign wdata    = wvalid ? head : '0;
  assign wstrb    = '1;
  assign awaddr   = awaddr_q;
  assign awlen    = awlen_q;
  assign awvalid  = awvalid_q;
  assign awsize   = 3'(LSB);
  assign awburst  = 2'b01;
  assign bready   = busy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

  assign aw_hs       = awvalid_q && awready;
  assign b_hs        = bvalid && busy_q;
  assign burst_beats = {1'b0, awlen_q} + 9'd1;
  assign addr_step   = ADDR_WIDTH'(burst_beats) << LSB;

  wr_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clock   (clock),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (s_tdata),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Next burst size: page room, max burst, and what is left of the frame.
  always_comb begin
    int unsigned room;
    int unsigned lim;
    room = B4K - 32'(cur_addr_q[11:LSB]);
    lim  = MAX_BURST;
    if (room < lim) lim = room;
    if (last_seen_q && (32'(count) < lim)) lim = 32'(count);
    len_d   = 9'(lim);
    issue_d = (out_q < OW'(MAX_OUTSTANDING))
           && (count != '0)
           && (32'(count) >= lim);
  end

  // Bursts awaiting a write response; AW and B together cancel out.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      unique case ({aw_hs, b_hs && (out_q != '0)})
        2'b10:   out_q <= out_q + OW'(1);
        2'b01:   out_q <= out_q - OW'(1);
        default: out_q <= out_q;
      endcase
    end
  end

  // Frame sequencer: burst issue, W beat counting, completion and error.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (b_hs && (bresp != 2'b00)) err_q <= 1'b1;
      if (push && s_tlast) last_seen_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cur_addr_q  <= base_addr;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (issue_d) begin
            awaddr_q  <= cur_addr_q;
            awlen_q   <= 8'(len_d - 9'd1);
            awvalid_q <= 1'b1;
            state_q   <= AW;
          end else if (last_seen_q && (count == '0)) begin
            state_q <= DRAIN;
          end
        end
        AW: begin
          if (awready) begin
            awvalid_q  <= 1'b0;
            beat_cnt_q <= burst_beats;
            state_q    <= W;
          end
        end
        W: begin
          if (pop) begin
            beat_cnt_q <= beat_cnt_q - 9'd1;
            if (beat_cnt_q == 9'd1) begin
              cur_addr_q <= cur_addr_q + addr_step;
              state_q    <= WAIT;
            end
          end
        end
        DRAIN: begin
          if (out_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_to_axi4_wr_burst.sv
// Directed bench for axis_to_axi4_wr_burst with stream/AW/W/B scoreboards.
// Expected bursts come from an address/length model of the frame.
module tb_axis_to_axi4_wr_burst;

  localparam int DEPTH = 128;
  localparam int MAXO  = 4;

  logic         clock = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [255:0] s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic         busy;
  logic         done;
  logic         err;

  axis_to_axi4_wr_burst dut (
    .clock(clock), .rst(rst), .start(start), .base_addr(base_addr),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] data_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [7:0]   exp_len_q[$];
  logic [7:0]   wlen_q[$];
  int           b_q[$];

  int  cyc = 0;
  int  fcount = 0, out = 0, max_out = 0;
  int  aw_cnt = 0, w_cnt = 0, done_cnt = 0, w_left = 0;
  int  aw_stall = 0, aw_wait = 0, b_delay = 2;
  int  b_idx = 0, b_err_idx = -1;
  int  done_base = 0, aw_base = 0, w_base = 0, frame_n = 0;
  bit  in_frame = 0, aw_pend = 0, abort = 0, saw_full = 0, w_rand = 0;
  logic [31:0] aw_prev_addr;
  logic [7:0]  aw_prev_len;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // AW slave: optional stall per burst before accepting.
  always @(posedge clock) begin
    #1;
    if (rst || !awvalid) begin
      awready = 1'b0;
      aw_wait = 0;
    end else begin
      awready = (aw_wait >= aw_stall);
      aw_wait++;
    end
  end

  // W slave: always ready or random 50%.
  always @(posedge clock) begin
    #1;
    wready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // B master: one response per completed burst after b_delay cycles.
  always @(posedge clock) begin
    #1;
    bvalid = 1'b0;
    bresp  = 2'b00;
    if (!rst && b_q.size() > 0 && cyc >= b_q[0]) begin
      void'(b_q.pop_front());
      bvalid = 1'b1;
      bresp  = (b_idx == b_err_idx) ? 2'b10 : 2'b00;
      b_idx++;
    end
  end

  // Monitor: samples at the falling edge, ahead of the next active edge.
  always @(negedge clock) begin
    if (!rst) begin
      if (fcount == DEPTH) begin
        chk("s_tready_full", s_tready, 1'b0);
        saw_full = 1;
      end else if (in_frame) begin
        chk("s_tready_open", s_tready, 1'b1);
      end
      if (s_tvalid && s_tready) begin
        data_q.push_back(s_tdata);
        fcount++;
        if (s_tlast) in_frame = 0;
      end
      if (aw_pend) begin
        chk("awvalid_hold", awvalid, 1'b1);
        chk("awaddr_stable", awaddr, aw_prev_addr);
        chk("awlen_stable", awlen, aw_prev_len);
      end
      aw_pend = awvalid && !awready;
      aw_prev_addr = awaddr;
      aw_prev_len  = awlen;
      if (awvalid && awready) begin
        chk("aw_expected", exp_addr_q.size() > 0, 1'b1);
        if (exp_addr_q.size() > 0) begin
          chk("awaddr", awaddr, exp_addr_q.pop_front());
          chk("awlen", awlen, exp_len_q.pop_front());
        end
        chk("aw_4k", (int'(awaddr[11:0]) + (int'(awlen) + 1) * 32) <= 4096,
            1'b1);
        out++;
        if (out > max_out) max_out = out;
        chk("outstanding_cap", out <= MAXO, 1'b1);
        wlen_q.push_back(awlen);
        aw_cnt++;
      end
      if (wvalid && wready) begin
        if (w_left == 0 && wlen_q.size() > 0)
          w_left = int'(wlen_q.pop_front()) + 1;
        chk("w_after_aw", w_left > 0, 1'b1);
        chk("w_data_avail", data_q.size() > 0, 1'b1);
        if (data_q.size() > 0) chk("wdata", wdata, data_q.pop_front());
        if (w_left > 0) w_left--;
        chk("wlast", wlast, w_left == 0);
        if (wlast) b_q.push_back(cyc + b_delay);
        fcount--;
        w_cnt++;
      end
      if (bvalid) begin
        chk("bready", bready, 1'b1);
        out--;
      end
      if (done) done_cnt++;
    end
  end

  task automatic plan_frame(input logic [31:0] base, input int n);
    logic [31:0] a;
    int rem, room, len;
    a = base;
    rem = n;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 32;
      len = 64;
      if (room < len) len = room;
      if (rem < len) len = rem;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(8'(len - 1));
      a = a + 32'(len * 32);
      rem -= len;
    end
  endtask

  task automatic send_frame(input int n);
    logic [255:0] d;
    bit hs;
    int guard;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      s_tdata  = d;
      s_tlast  = (i == n - 1);
      s_tvalid = 1'b1;
      guard = 0;
      do begin
        @(negedge clock);
        hs = s_tready;
        @(posedge clock);
        #1;
        guard++;
      end while (!hs && !abort && guard < 5000);
      if (abort) break;
      chk("stream_timeout", hs, 1'b1);
      if (!hs) break;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic begin_frame(input logic [31:0] base, input int n);
    plan_frame(base, n);
    base_addr = base;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    in_frame  = 1;
    done_base = done_cnt;
    aw_base   = aw_cnt;
    w_base    = w_cnt;
    frame_n   = n;
    fork
      send_frame(frame_n);
    join_none
  endtask

  task automatic wait_done(input int limit);
    int g;
    g = 0;
    while (done_cnt == done_base && g < limit) begin
      @(posedge clock);
      #1;
      g++;
    end
    chk("done_timeout", done_cnt != done_base, 1'b1);
  endtask

  task automatic end_checks(input int n_aw);
    chk("busy_after_done", busy, 1'b0);
    chk("aw_count", aw_cnt - aw_base, n_aw);
    chk("aw_all_seen", exp_addr_q.size(), 0);
    chk("data_all_seen", data_q.size(), 0);
    chk("b_all_seen", out, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("done_once", done_cnt - done_base, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    s_tdata = '0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    bresp = 2'b00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_awsize", awsize, 3'd5);
    chk("rst_awburst", awburst, 2'b01);
    chk("rst_wstrb", wstrb, 32'hFFFF_FFFF);
    @(posedge clock);
    #1;
    rst = 1'b0;

    // 256 beats from 0: four full bursts
    begin_frame(32'h0, 256);
    wait_done(3000);
    chk("t1_err", err, 1'b0);
    end_checks(4);

    // 10 beats just below a 4KB page
    begin_frame(32'h0000_0F80, 10);
    wait_done(500);
    end_checks(2);

    // single-beat frame
    begin_frame(32'h0000_2000, 1);
    wait_done(500);
    end_checks(1);

    // AW stalls, random W back-pressure, FIFO fills
    aw_stall = 20;
    w_rand = 1;
    saw_full = 0;
    begin_frame(32'h0001_0000, 512);
    wait_done(20000);
    chk("fifo_full_seen", saw_full, 1'b1);
    end_checks(8);
    aw_stall = 0;
    w_rand = 0;

    // slow responses cap outstanding; 2nd response is SLVERR
    b_delay = 300;
    b_idx = 0;
    b_err_idx = 1;
    max_out = 0;
    begin_frame(32'h0002_0000, 384);
    repeat (10) @(posedge clock);
    #1;
    base_addr = 32'h0009_0000;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(20000);
    chk("max_outstanding", max_out, MAXO);
    chk("err_set", err, 1'b1);
    end_checks(6);
    repeat (5) @(posedge clock);
    #1;
    chk("err_sticky", err, 1'b1);
    b_delay = 2;
    b_err_idx = -1;

    // reset in the middle of the second burst's W phase
    begin_frame(32'h0003_0000, 200);
    chk("err_cleared", err, 1'b0);
    for (int g = 0; g < 3000 && (w_cnt - w_base) < 74; g++) begin
      @(posedge clock);
      #1;
    end
    chk("mid_w_reached", (w_cnt - w_base) >= 74, 1'b1);
    rst = 1'b1;
    abort = 1;
    @(negedge clock);
    chk("abort_awvalid", awvalid, 1'b0);
    chk("abort_wvalid", wvalid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_s_tready", s_tready, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    data_q.delete();
    exp_addr_q.delete();
    exp_len_q.delete();
    wlen_q.delete();
    b_q.delete();
    fcount = 0;
    out = 0;
    w_left = 0;
    in_frame = 0;
    aw_pend = 0;
    abort = 0;
    rst = 1'b0;
    @(negedge clock);
    chk("post_rst_wvalid", wvalid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    @(posedge clock);
    #1;
    begin_frame(32'h0000_0040, 3);
    wait_done(500);
    chk("post_rst_err", err, 1'b0);
    end_checks(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
